csr_trap_ctrl: RTL

//   Sequences machine-mode trap entry and MRET return through the single-ported CSR file
//   (mstatus 0x300, mepc 0x341, optional mcause 0x342).

---
 rtl/csr_trap_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequences machine-mode interrupt entry and MRET return
// through the single-ported CSR file (mstatus 0x300, mepc 0x341, mcause 0x342).
// While a sequence runs, this block owns the CSR port and stalls the pipeline.
// It also redirects the PC at the end of each sequence.
// Optional feature macro: CSR_TRAP_MCAUSE_EN. When it is defined, the
// CAUSE_WR state writes IRQ_CAUSE to mcause before the PC is redirected.
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC = 32'h0000_0100
`ifdef CSR_TRAP_MCAUSE_EN
  , parameter logic [31:0] IRQ_CAUSE = 32'h8000_000B
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc,
  input  logic        i_instr_vld,
  input  logic        i_ext_irq,
  input  logic        i_is_mret,
  input  logic        i_mie,
  input  logic [31:0] i_csr_rdata,
  output logic [31:0] o_csr_addr,
  output logic [31:0] o_csr_wdata,
  output logic        o_csr_rd,
  output logic        o_csr_wr,
  output logic        o_busy,
  output logic        o_flush,
  output logic        o_pc_load,
  output logic [31:0] o_pc_target
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
`ifdef CSR_TRAP_MCAUSE_EN
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
`endif

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_EPC_WR   = 4'd1,
    S_ST_RD    = 4'd2,
    S_ST_WR    = 4'd3,
`ifdef CSR_TRAP_MCAUSE_EN
    S_CAUSE_WR = 4'd4,
`endif
    S_REDIR    = 4'd5,
    S_MR_RD    = 4'd6,
    S_MR_WR    = 4'd7,
    S_MR_JMP   = 4'd8
  } state_t;

  state_t      r_state;
  logic [31:0] r_epc;
  logic [31:0] r_status;
  logic [11:0] r_csr_addr;
  logic        r_csr_rd;
  logic        r_csr_wr;
  logic        r_busy;
  logic        r_pc_load;

  logic        w_idle;
  logic        w_acc_mret;
  logic        w_acc_irq;
  logic [31:0] w_status_entry;
  logic [31:0] w_status_ret;
  logic [31:0] w_wdata;
  logic [31:0] w_target;

  // MRET has priority over an interrupt in the same cycle. A masked
  // interrupt is simply ignored and is never remembered.
  assign w_idle     = (r_state == S_IDLE);
  assign w_acc_mret = w_idle & i_instr_vld & i_is_mret;
  assign w_acc_irq  = w_idle & i_instr_vld & ~i_is_mret & i_ext_irq & i_mie;

  // Entry: MPIE <= MIE, MIE <= 0. Return: MIE <= MPIE, MPIE <= 1.
  assign w_status_entry = {r_status[31:8], r_status[3], r_status[6:4], 1'b0, r_status[2:0]};
  assign w_status_ret   = {r_status[31:8], 1'b1, r_status[6:4], r_status[7], r_status[2:0]};

  // State sequencing; strobes and address are registered for the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_epc      <= '0;
      r_status   <= '0;
      r_csr_addr <= '0;
      r_csr_rd   <= 1'b0;
      r_csr_wr   <= 1'b0;
      r_busy     <= 1'b0;
      r_pc_load  <= 1'b0;
    end else begin
      r_csr_addr <= '0;
      r_csr_rd   <= 1'b0;
      r_csr_wr   <= 1'b0;
      r_busy     <= 1'b0;
      r_pc_load  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc_mret) begin
            r_state    <= S_MR_RD;
            r_busy     <= 1'b1;
            r_csr_rd   <= 1'b1;
            r_csr_addr <= CSR_MSTATUS;
          end else if (w_acc_irq) begin
            r_epc      <= i_pc;
            r_state    <= S_EPC_WR;
            r_busy     <= 1'b1;
            r_csr_wr   <= 1'b1;
            r_csr_addr <= CSR_MEPC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EPC_WR: begin
          r_state    <= S_ST_RD;
          r_busy     <= 1'b1;
          r_csr_rd   <= 1'b1;
          r_csr_addr <= CSR_MSTATUS;
        end
        S_ST_RD: begin
          r_status   <= i_csr_rdata;
          r_state    <= S_ST_WR;
          r_busy     <= 1'b1;
          r_csr_wr   <= 1'b1;
          r_csr_addr <= CSR_MSTATUS;
        end
        S_ST_WR: begin
`ifdef CSR_TRAP_MCAUSE_EN
          r_state    <= S_CAUSE_WR;
          r_busy     <= 1'b1;
          r_csr_wr   <= 1'b1;
          r_csr_addr <= CSR_MCAUSE;
`else
          r_state    <= S_REDIR;
          r_busy     <= 1'b1;
          r_pc_load  <= 1'b1;
`endif
        end
`ifdef CSR_TRAP_MCAUSE_EN
        S_CAUSE_WR: begin
          r_state   <= S_REDIR;
          r_busy    <= 1'b1;
          r_pc_load <= 1'b1;
        end
`endif
        S_REDIR: begin
          r_state <= S_IDLE;
        end
        S_MR_RD: begin
          r_status   <= i_csr_rdata;
          r_state    <= S_MR_WR;
          r_busy     <= 1'b1;
          r_csr_wr   <= 1'b1;
          r_csr_addr <= CSR_MSTATUS;
        end
        S_MR_WR: begin
          r_state    <= S_MR_JMP;
          r_busy     <= 1'b1;
          r_csr_rd   <= 1'b1;
          r_csr_addr <= CSR_MEPC;
          r_pc_load  <= 1'b1;
        end
        S_MR_JMP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Data outputs decoded from the current state; the MRET target is the live mepc read
  always_comb begin
    w_wdata  = '0;
    w_target = '0;
    case (r_state)
      S_EPC_WR:   w_wdata  = r_epc;
      S_ST_WR:    w_wdata  = w_status_entry;
`ifdef CSR_TRAP_MCAUSE_EN
      S_CAUSE_WR: w_wdata  = IRQ_CAUSE;
`endif
      S_MR_WR:    w_wdata  = w_status_ret;
      S_REDIR:    w_target = MTVEC;
      S_MR_JMP:   w_target = i_csr_rdata;
      default:    ;
    endcase
  end

  assign o_csr_addr  = {20'b0, r_csr_addr};
  assign o_csr_wdata = w_wdata;
  assign o_csr_rd    = r_csr_rd;
  assign o_csr_wr    = r_csr_wr;
  assign o_busy      = r_busy;
  assign o_pc_load   = r_pc_load;
  assign o_pc_target = w_target;
  // The state is already IDLE while rst is high, so flush is masked explicitly
  // to keep every output low during reset.
  assign o_flush     = ~rst & w_acc_irq;

endmodule
